// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared widths, op/requester encodings and the shift function
//               used by the shift_arbiter datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

   localparam int SH_WIDTH = 16;
   localparam int SH_AMT_W = 4;

   localparam logic MODE_SLL = 1'b1;
   localparam logic MODE_SRA = 1'b0;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_AGU = 1'b1;

   typedef struct packed {
      logic [SH_WIDTH-1:0] data;
      logic [SH_AMT_W-1:0] amt;
      logic                mode;
   } shift_req_t;

   // SLL zero-fills; SRA replicates the sign bit; amt=0 is a pass-through.
   function automatic logic [SH_WIDTH-1:0] shift_op(input shift_req_t r);
      logic [SH_WIDTH-1:0] res;
      if (r.mode == MODE_SLL)
         res = r.data << r.amt;
      else
         res = $signed(r.data) >>> r.amt;
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/shift_arbiter_rr_pick2.sv
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin grant. A lone requester always wins;
//               under contention the requester not granted last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
   input  logic [1:0] valid,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
// Module      : shift_arbiter
// Description : Round-robin share of one 16-bit shifter between two
//               valid/ready requesters with a single registered result.
//               Optional grant counters when SHIFT_ARB_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_arbiter
   import shift_pkg::*;
#(
   parameter int WIDTH = SH_WIDTH,
   parameter int AMT_W = SH_AMT_W,
   parameter int NREQ  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   input  logic [WIDTH-1:0] req0_data,
   input  logic [AMT_W-1:0] req0_amt,
   input  logic             req0_mode,
   input  logic [WIDTH-1:0] req1_data,
   input  logic [AMT_W-1:0] req1_amt,
   input  logic             req1_mode,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id
`ifdef SHIFT_ARB_PERF_EN
   ,
   output logic [15:0]      grant_cnt0,
   output logic [15:0]      grant_cnt1
`endif
);

   logic             r_rsp_valid;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_id;
   logic             r_last_grant;

   logic             w_slot_free;
   logic [1:0]       w_gnt;
   logic             w_hs;
   logic             w_sel;
   shift_req_t       w_op;

   // The slot can refill in the same cycle it drains, giving 1 result/cycle.
   assign w_slot_free = !r_rsp_valid || rsp_ready;

   rr_pick2 u_pick (
      .valid (req_valid),
      .last  (r_last_grant),
      .en    (w_slot_free && !rst),
      .gnt   (w_gnt)
   );

   assign req_ready = w_gnt;
   assign w_hs      = |(req_valid & w_gnt);
   assign w_sel     = w_gnt[1];

   always_comb begin
      w_op = '{data: req0_data, amt: req0_amt, mode: req0_mode};
      if (w_sel == REQ_AGU)
         w_op = '{data: req1_data, amt: req1_amt, mode: req1_mode};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_id     <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_hs) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_data   <= shift_op(w_op);
         r_rsp_id     <= w_sel;
         r_last_grant <= w_sel;
      end else if (rsp_ready) begin
         r_rsp_valid  <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;

`ifdef SHIFT_ARB_PERF_EN
   logic [15:0] r_grant_cnt0;
   logic [15:0] r_grant_cnt1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant_cnt0 <= '0;
         r_grant_cnt1 <= '0;
      end else begin
         if (req_valid[0] && w_gnt[0] && r_grant_cnt0 != 16'hFFFF)
            r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
         if (req_valid[1] && w_gnt[1] && r_grant_cnt1 != 16'hFFFF)
            r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
      end
   end

   assign grant_cnt0 = r_grant_cnt0;
   assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// Module      : tb_shift_arbiter
// Description : Directed self-checking bench for shift_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req0_data, req1_data;
   logic [3:0]  req0_amt, req1_amt;
   logic        req0_mode, req1_mode;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [15:0] rsp_data;
`ifdef SHIFT_ARB_PERF_EN
   logic [15:0] grant_cnt0, grant_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req0_data (req0_data),
      .req0_amt  (req0_amt),
      .req0_mode (req0_mode),
      .req1_data (req1_data),
      .req1_amt  (req1_amt),
      .req1_mode (req1_mode),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
`ifdef SHIFT_ARB_PERF_EN
      ,
      .grant_cnt0(grant_cnt0),
      .grant_cnt1(grant_cnt1)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      req0_data = 16'h1111; req0_amt = 4'd1; req0_mode = 1'b1;
      req1_data = 16'h2222; req1_amt = 4'd1; req1_mode = 1'b1;
      step();
      step();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b data=%h id=%b expected 0 0000 0", rsp_valid, rsp_data, rsp_id);
      end
      checks++;
      if (req_ready !== 2'b00) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 00", req_ready);
      end
      rst = 1'b0;
      req_valid = 2'b00;
   endtask

   task automatic test_req0_sra();
      req_valid = 2'b01;
      req0_data = 16'h8001; req0_amt = 4'd4; req0_mode = 1'b0;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL req0_ready: got %b expected 01", req_ready);
      end
      step();
      req_valid = 2'b00;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hF800 || rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL req0_sra: valid=%b data=%h id=%b expected 1 f800 0", rsp_valid, rsp_data, rsp_id);
      end
   endtask

   task automatic test_req1_sll();
      req_valid = 2'b10;
      req1_data = 16'h0003; req1_amt = 4'd15; req1_mode = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL req1_ready: got %b expected 10", req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h8000 || rsp_id !== 1'b1) begin
         errors++;
         $display("FAIL req1_sll15: valid=%b data=%h id=%b expected 1 8000 1", rsp_valid, rsp_data, rsp_id);
      end
      req1_data = 16'h1234; req1_amt = 4'd0; req1_mode = 1'b0;
      step();
      req_valid = 2'b00;
      checks++;
      if (rsp_data !== 16'h1234 || rsp_id !== 1'b1) begin
         errors++;
         $display("FAIL req1_amt0: data=%h id=%b expected 1234 1", rsp_data, rsp_id);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty: rsp_valid=%b expected 0", rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      logic [15:0] exp_dat [4] = '{16'h0F00, 16'hFF00, 16'h0F00, 16'hFF00};
      do_reset();
      rsp_ready = 1'b1;
      req0_data = 16'h00F0; req0_amt = 4'd4; req0_mode = 1'b1;
      req1_data = 16'hF000; req1_amt = 4'd4; req1_mode = 1'b0;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (req_ready !== exp_rdy[i]) begin
            errors++;
            $display("FAIL rr_ready[%0d]: got %b expected %b", i, req_ready, exp_rdy[i]);
         end
         step();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== exp_rdy[i][1] || rsp_data !== exp_dat[i]) begin
            errors++;
            $display("FAIL rr_rsp[%0d]: valid=%b id=%b data=%h expected 1 %b %h",
                     i, rsp_valid, rsp_id, rsp_data, exp_rdy[i][1], exp_dat[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      // Holding result from requester 1 (0xFF00) after the round-robin run.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_ready[%0d]: got %b expected 00", i, req_ready);
         end
         step();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 16'hFF00 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%b expected 1 ff00 1", i, rsp_valid, rsp_data, rsp_id);
         end
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL bp_release_ready: got %b expected 01", req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h0F00 || rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL bp_release_rsp: valid=%b data=%h id=%b expected 1 0f00 0", rsp_valid, rsp_data, rsp_id);
      end
   endtask

   task automatic test_mid_reset();
      // Last grant was requester 0; after reset requester 0 must still win.
      rst = 1'b1;
      step();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000) begin
         errors++;
         $display("FAIL midrst_clear: valid=%b data=%h expected 0 0000", rsp_valid, rsp_data);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL midrst_ready: got %b expected 01", req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL midrst_winner: valid=%b id=%b expected 1 0", rsp_valid, rsp_id);
      end
      req_valid = 2'b00;
   endtask

`ifdef SHIFT_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      rsp_ready = 1'b1;
      checks++;
      if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
         errors++;
         $display("FAIL perf_reset: cnt0=%0d cnt1=%0d expected 0 0", grant_cnt0, grant_cnt1);
      end
      req_valid = 2'b01;
      repeat (5) step();
      req_valid = 2'b10;
      repeat (2) step();
      req_valid = 2'b00;
      step();
      checks++;
      if (grant_cnt0 !== 16'd5 || grant_cnt1 !== 16'd2) begin
         errors++;
         $display("FAIL perf_count: cnt0=%0d cnt1=%0d expected 5 2", grant_cnt0, grant_cnt1);
      end
      req_valid = 2'b01;
      repeat (65530) step();
      checks++;
      if (grant_cnt0 !== 16'hFFFF) begin
         errors++;
         $display("FAIL perf_reach_max: cnt0=%h expected ffff", grant_cnt0);
      end
      step();
      req_valid = 2'b00;
      checks++;
      if (grant_cnt0 !== 16'hFFFF) begin
         errors++;
         $display("FAIL perf_saturate: cnt0=%h expected ffff", grant_cnt0);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      req0_data = '0; req0_amt = '0; req0_mode = 1'b0;
      req1_data = '0; req1_amt = '0; req1_mode = 1'b0;
      test_reset();
      test_req0_sra();
      test_req1_sll();
      test_round_robin();
      test_backpressure();
      test_mid_reset();
`ifdef SHIFT_ARB_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
